// File: rtl/dso100fb_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dso100fb_timing_gen_if : config inputs and timing outputs of the timing gen |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface dso100fb_timing_gen_if #(
  parameter int CW   = 12,
  parameter int NWIN = 2
);
  logic                 i_en;
  logic [CW-1:0]        i_hactive, i_hfp, i_hsyncw, i_hbp;
  logic [CW-1:0]        i_vactive, i_vfp, i_vsyncw, i_vbp;
  logic                 i_hsync_pol, i_vsync_pol, i_de_pol;
  logic [NWIN*CW-1:0]   i_win_x0, i_win_x1, i_win_y0, i_win_y1;
  logic [CW-1:0]        i_line_cmp;
  logic                 i_update;
  logic                 o_de, o_hsync, o_vsync, o_fetch;
  logic [NWIN-1:0]      o_win_en;
  logic                 o_frame, o_line_irq, o_update_done;

  modport master (
    output i_en, i_hactive, i_hfp, i_hsyncw, i_hbp, i_vactive, i_vfp, i_vsyncw, i_vbp,
           i_hsync_pol, i_vsync_pol, i_de_pol, i_win_x0, i_win_x1, i_win_y0, i_win_y1,
           i_line_cmp, i_update,
    input  o_de, o_hsync, o_vsync, o_fetch, o_win_en, o_frame, o_line_irq, o_update_done
  );

  modport slave (
    input  i_en, i_hactive, i_hfp, i_hsyncw, i_hbp, i_vactive, i_vfp, i_vsyncw, i_vbp,
           i_hsync_pol, i_vsync_pol, i_de_pol, i_win_x0, i_win_x1, i_win_y0, i_win_y1,
           i_line_cmp, i_update,
    output o_de, o_hsync, o_vsync, o_fetch, o_win_en, o_frame, o_line_irq, o_update_done
  );
endinterface
`default_nettype wire

// File: rtl/dso100fb_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dso100fb_timing_gen : shadowed video timing generator with overlay windows |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module dso100fb_timing_gen #(
  parameter int CW   = 12,
  parameter int NWIN = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  dso100fb_timing_gen_if.slave  bus
);
  localparam int c_TW = CW + 2;
  localparam logic [c_TW-1:0] c_ONE = c_TW'(1);

  logic [CW-1:0]      r_hact, r_hfp, r_hsw, r_hbp, r_vact, r_vfp, r_vsw, r_vbp, r_line_cmp;
  logic               r_hs_pol, r_vs_pol, r_de_pol;
  logic [NWIN*CW-1:0] r_x0, r_x1, r_y0, r_y1;
  logic               r_run, r_pend;
  logic [c_TW-1:0]    r_hc, r_vc;
  logic               r_de, r_hsync, r_vsync, r_fetch, r_frame, r_line_irq, r_update_done;
  logic [NWIN-1:0]    r_win_en;

  logic [c_TW-1:0]    w_hs_start, w_hs_end, w_htot, w_vs_start, w_vs_end, w_vtot;
  logic               w_zero, w_hlast, w_vlast, w_load, w_live, w_fetch, w_hs_ph, w_vs_ph;
  logic               w_hs_pol_nx, w_vs_pol_nx, w_de_pol_nx;
  logic [NWIN-1:0]    w_win;

  assign w_hs_start = c_TW'(r_hact) + c_TW'(r_hfp);
  assign w_hs_end   = w_hs_start + c_TW'(r_hsw);
  assign w_htot     = w_hs_end + c_TW'(r_hbp);
  assign w_vs_start = c_TW'(r_vact) + c_TW'(r_vfp);
  assign w_vs_end   = w_vs_start + c_TW'(r_vsw);
  assign w_vtot     = w_vs_end + c_TW'(r_vbp);

  assign w_zero  = (w_htot == '0) || (w_vtot == '0);
  assign w_hlast = !w_zero && (r_hc == w_htot - c_ONE);
  assign w_vlast = !w_zero && (r_vc == w_vtot - c_ONE);

  // Load on the first enabled cycle, or at the frame end with an update pending.
  assign w_load = bus.i_en && (!r_run || (w_hlast && w_vlast && r_pend));
  assign w_live = r_run && bus.i_en && !w_zero;

  assign w_fetch = (r_hc < c_TW'(r_hact)) && (r_vc < c_TW'(r_vact));
  assign w_hs_ph = (r_hc >= w_hs_start) && (r_hc < w_hs_end);
  assign w_vs_ph = (r_vc >= w_vs_start) && (r_vc < w_vs_end);

  assign w_hs_pol_nx = w_load ? bus.i_hsync_pol : r_hs_pol;
  assign w_vs_pol_nx = w_load ? bus.i_vsync_pol : r_vs_pol;
  assign w_de_pol_nx = w_load ? bus.i_de_pol    : r_de_pol;

  for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
    logic [c_TW-1:0] w_x0, w_x1, w_y0, w_y1;
    assign w_x0 = c_TW'(r_x0[gi*CW +: CW]);
    assign w_x1 = c_TW'(r_x1[gi*CW +: CW]);
    assign w_y0 = c_TW'(r_y0[gi*CW +: CW]);
    assign w_y1 = c_TW'(r_y1[gi*CW +: CW]);
    assign w_win[gi] = w_fetch && (r_hc >= w_x0) && (r_hc < w_x1) &&
                       (r_vc >= w_y0) && (r_vc < w_y1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hact <= '0; r_hfp <= '0; r_hsw <= '0; r_hbp <= '0;
      r_vact <= '0; r_vfp <= '0; r_vsw <= '0; r_vbp <= '0;
      r_line_cmp <= '0;
      r_hs_pol <= 1'b0; r_vs_pol <= 1'b0; r_de_pol <= 1'b0;
      r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
    end else if (w_load) begin
      r_hact <= bus.i_hactive; r_hfp <= bus.i_hfp; r_hsw <= bus.i_hsyncw; r_hbp <= bus.i_hbp;
      r_vact <= bus.i_vactive; r_vfp <= bus.i_vfp; r_vsw <= bus.i_vsyncw; r_vbp <= bus.i_vbp;
      r_line_cmp <= bus.i_line_cmp;
      r_hs_pol <= bus.i_hsync_pol; r_vs_pol <= bus.i_vsync_pol; r_de_pol <= bus.i_de_pol;
      r_x0 <= bus.i_win_x0; r_x1 <= bus.i_win_x1; r_y0 <= bus.i_win_y0; r_y1 <= bus.i_win_y1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run  <= 1'b0;
      r_pend <= 1'b0;
      r_hc   <= '0;
      r_vc   <= '0;
    end else begin
      r_run <= bus.i_en;
      // An update landing on the load cycle itself stays pending for the next frame.
      if (!bus.i_en)         r_pend <= 1'b0;
      else if (bus.i_update) r_pend <= 1'b1;
      else if (w_load)       r_pend <= 1'b0;

      if (!bus.i_en || !r_run || w_zero) begin
        r_hc <= '0;
        r_vc <= '0;
      end else if (w_hlast) begin
        r_hc <= '0;
        r_vc <= w_vlast ? '0 : r_vc + c_ONE;
      end else begin
        r_hc <= r_hc + c_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de <= 1'b0; r_hsync <= 1'b0; r_vsync <= 1'b0; r_fetch <= 1'b0;
      r_win_en <= '0; r_frame <= 1'b0; r_line_irq <= 1'b0; r_update_done <= 1'b0;
    end else begin
      r_update_done <= w_load;
      if (w_live) begin
        r_fetch    <= w_fetch;
        r_de       <= w_fetch ^ ~r_de_pol;
        r_hsync    <= w_hs_ph ^ ~r_hs_pol;
        r_vsync    <= w_vs_ph ^ ~r_vs_pol;
        r_win_en   <= w_win;
        r_frame    <= w_hlast && w_vlast;
        r_line_irq <= (r_hc == '0) && (r_vc == c_TW'(r_line_cmp));
      end else begin
        r_fetch    <= 1'b0;
        r_win_en   <= '0;
        r_frame    <= 1'b0;
        r_line_irq <= 1'b0;
        // Idle since reset keeps the reset levels until the first enable.
        if (bus.i_en || r_run) begin
          r_de    <= ~w_de_pol_nx;
          r_hsync <= ~w_hs_pol_nx;
          r_vsync <= ~w_vs_pol_nx;
        end
      end
    end
  end

  assign bus.o_de          = r_de;
  assign bus.o_hsync       = r_hsync;
  assign bus.o_vsync       = r_vsync;
  assign bus.o_fetch       = r_fetch;
  assign bus.o_win_en      = r_win_en;
  assign bus.o_frame       = r_frame;
  assign bus.o_line_irq    = r_line_irq;
  assign bus.o_update_done = r_update_done;
endmodule
`default_nettype wire
